secuenciador: RTL and testbench

SECUENCIADOR -- requirements
Module: secuenciador

---
 rtl/secuenciador_pkg.sv | 15 +
 rtl/secuenciador_contador_pc.sv | 40 ++++
 rtl/secuenciador.sv | 145 ++++++++++++++
 tb/tb_secuenciador.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_pkg.sv
// Shared constants for the secuenciador program sequencer: FSM state
// encodings (3-bit, legacy-compatible values) and default parameters.
package secuenciador_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_EXEC  = 3'd2;
   localparam logic [2:0] ST_FIN   = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   localparam int unsigned DEF_W    = 8;
   localparam logic [7:0]  DEF_LAST = 8'hFF;
   localparam int unsigned DEF_TMO  = 16;

endpackage

// File: rtl/secuenciador_contador_pc.sv
// contador_pc: loadable W-bit up-counter holding the sequencer's program
// counter. load wins over inc; with both low the value holds.
module contador_pc
   import secuenciador_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Next value: load has priority, increment wraps modulo 2^W.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (inc) begin
         q_d = q_q + 1'b1;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/secuenciador.sv
// secuenciador: fetch/execute program sequencer. Walks pc from start_addr
// to LAST, issuing a mem_req handshake per address, with branch and abort.
// Optional mem_ack watchdog: define SECUENCIADOR_TIMEOUT_EN.
module secuenciador
   import secuenciador_pkg::*;
#(
   parameter int unsigned  W    = DEF_W,
   parameter logic [W-1:0] LAST = W'(DEF_LAST),
   parameter int unsigned  TMO  = DEF_TMO
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [W-1:0] start_addr,
   input  logic         halt,
   input  logic         jmp,
   input  logic [W-1:0] jmp_addr,
   input  logic         mem_ack,
   output logic [W-1:0] pc,
   output logic         mem_req,
   output logic         busy,
   output logic         done,
   output logic         err
);

   logic [2:0]   state_q;
   logic [2:0]   state_d;
   logic         mem_req_q;
   logic         pc_load;
   logic         pc_inc;
   logic [W-1:0] pc_ld_val;
   logic         wd_expired;

   // A zero timeout has no meaningful watchdog behaviour.
   always_comb assert (TMO > 0);

`ifdef SECUENCIADOR_TIMEOUT_EN
   localparam int unsigned WD_W = (TMO > 1) ? $clog2(TMO) : 1;

   logic [WD_W-1:0] wd_q;
   logic [WD_W-1:0] wd_d;

   assign wd_expired = (wd_q == WD_W'(TMO - 1));

   // Count consecutive unacknowledged FETCH cycles; zero on any other path.
   always_comb begin
      wd_d = '0;
      if (state_q == ST_FETCH && state_d == ST_FETCH) begin
         wd_d = wd_q + 1'b1;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   assign err = (state_q == ST_ERR);
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   // Next-state and pc control; halt overrides ack, branch and end-of-run.
   always_comb begin
      state_d   = state_q;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_ld_val = start_addr;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_load = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (halt) begin
               state_d = ST_IDLE;
            end else if (mem_ack) begin
               state_d = ST_EXEC;
            end else if (wd_expired) begin
               state_d = ST_ERR;
            end
         end
         ST_EXEC: begin
            if (halt) begin
               state_d = ST_IDLE;
            end else if (jmp) begin
               pc_load   = 1'b1;
               pc_ld_val = jmp_addr;
               state_d   = ST_FETCH;
            end else if (pc != LAST) begin
               pc_inc  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (start) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; mem_req is registered alongside so it is glitch-free.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= (state_d == ST_FETCH);
      end
   end

   contador_pc #(
      .W (W)
   ) u_pc (
      .clk      (clk),
      .rstn     (rstn),
      .load     (pc_load),
      .load_val (pc_ld_val),
      .inc      (pc_inc),
      .q        (pc)
   );

   assign mem_req = mem_req_q;
   assign busy    = (state_q != ST_IDLE);
   // A halt during FIN suppresses the completion pulse.
   assign done    = (state_q == ST_FIN) && !halt;

endmodule

// File: tb/tb_secuenciador.sv
// Self-checking bench for secuenciador with default parameters
// (W=8, LAST=8'hFF, TMO=16).
module tb_secuenciador;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic [7:0] start_addr = '0;
   logic       halt = 1'b0;
   logic       jmp = 1'b0;
   logic [7:0] jmp_addr = '0;
   logic       mem_ack = 1'b0;
   logic [7:0] pc;
   logic       mem_req;
   logic       busy;
   logic       done;
   logic       err;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   secuenciador dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .start_addr (start_addr),
      .halt       (halt),
      .jmp        (jmp),
      .jmp_addr   (jmp_addr),
      .mem_ack    (mem_ack),
      .pc         (pc),
      .mem_req    (mem_req),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      checks++;
      if (pc !== 8'h00) begin
         errors++; $display("FAIL rst_pc got %h want 00", pc);
      end
      checks++;
      if ({mem_req, busy, done, err} !== 4'b0000) begin
         errors++; $display("FAIL rst_flags got %b want 0000", {mem_req, busy, done, err});
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_idle_busy got %b want 0", busy);
      end
   endtask

   task automatic test_linear();
      logic [7:0] want;
      int         dones = 0;
      logic       prev_done = 1'b0;
      exp_q = {8'hFC, 8'hFD, 8'hFE, 8'hFF};
      start_addr = 8'hFC; mem_ack = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (mem_req === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL lin_extra_fetch got pc %h want no fetch", pc);
            end else begin
               want = exp_q.pop_front();
               if (pc !== want) begin
                  errors++; $display("FAIL lin_pc got %h want %h", pc, want);
               end
            end
         end
         if (prev_done && !done) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++; $display("FAIL lin_busy_fall got %b want 0", busy);
            end
         end
         if (done === 1'b1) dones++;
         prev_done = done;
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if (dones != 1) begin
         errors++; $display("FAIL lin_done_pulses got %0d want 1", dones);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL lin_missing_fetches got %0d want 0", exp_q.size());
      end
      checks++;
      if (pc !== 8'hFF) begin
         errors++; $display("FAIL lin_final_pc got %h want FF", pc);
      end
   endtask

   task automatic test_branch();
      logic [7:0] want;
      exp_q = {8'h0A, 8'h20};
      start_addr = 8'h0A; mem_ack = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, pc} !== {1'b1, want}) begin
         errors++; $display("FAIL br_fetch0 got %b/%h want 1/%h", mem_req, pc, want);
      end
      tick();
      checks++;
      if ({mem_req, busy} !== 2'b01) begin
         errors++; $display("FAIL br_exec got req/busy %b want 01", {mem_req, busy});
      end
      jmp = 1'b1; jmp_addr = 8'h20;
      tick();
      jmp = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, pc} !== {1'b1, want}) begin
         errors++; $display("FAIL br_target got %b/%h want 1/%h", mem_req, pc, want);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0; mem_ack = 1'b0;
      checks++;
      if ({busy, pc} !== {1'b0, 8'h20}) begin
         errors++; $display("FAIL br_halt got %b/%h want 0/20", busy, pc);
      end
   endtask

   task automatic test_last_jump();
      logic [7:0] want;
      exp_q = {8'hFF, 8'h05};
      start_addr = 8'hFF; mem_ack = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if (pc !== want) begin
         errors++; $display("FAIL lj_fetch got %h want %h", pc, want);
      end
      tick();
      jmp = 1'b1; jmp_addr = 8'h05;
      tick();
      jmp = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, done, pc} !== {1'b1, 1'b0, want}) begin
         errors++; $display("FAIL lj_branch got %b%b/%h want 10/%h", mem_req, done, pc, want);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic test_wait();
      logic [7:0] want;
      exp_q = {8'h0A};
      start_addr = 8'h0A; mem_ack = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({mem_req, pc} !== {1'b1, exp_q[0]}) begin
            errors++; $display("FAIL ws_hold%0d got %b/%h want 1/%h", c, mem_req, pc, exp_q[0]);
         end
         start = (c == 1);
         start_addr = 8'h77;
         if (c < 4) tick();
      end
      start = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, busy, pc} !== {2'b01, want}) begin
         errors++; $display("FAIL ws_exec got %b%b/%h want 01/%h", mem_req, busy, pc, want);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
   endtask

   task automatic test_halt();
      start_addr = 8'h12; mem_ack = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      halt = 1'b1; mem_ack = 1'b1;
      tick();
      halt = 1'b0;
      checks++;
      if ({busy, mem_req, done, pc} !== {3'b000, 8'h12}) begin
         errors++; $display("FAIL halt_prio got %b%b%b/%h want 000/12", busy, mem_req, done, pc);
      end
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({busy, mem_req} !== 2'b00) begin
         errors++; $display("FAIL halt_ack_idle got %b want 00", {busy, mem_req});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] want;
      exp_q = {8'h40, 8'h07};
      start_addr = 8'h40; mem_ack = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, pc} !== {1'b1, want}) begin
         errors++; $display("FAIL rm_fetch got %b/%h want 1/%h", mem_req, pc, want);
      end
      #3 rstn = 1'b0;
      #1;
      checks++;
      if ({mem_req, busy, pc} !== {2'b00, 8'h00}) begin
         errors++; $display("FAIL rm_async got %b%b/%h want 00/00", mem_req, busy, pc);
      end
      #1 rstn = 1'b1;
      start_addr = 8'h07; start = 1'b1;
      tick();
      start = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if ({mem_req, pc} !== {1'b1, want}) begin
         errors++; $display("FAIL rm_first_start got %b/%h want 1/%h", mem_req, pc, want);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
   endtask

`ifdef SECUENCIADOR_TIMEOUT_EN
   task automatic test_timeout();
      start_addr = 8'h33; mem_ack = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 16; c++) begin
         tick();
         checks++;
         if ({err, mem_req} !== 2'b01) begin
            errors++; $display("FAIL to_wait%0d got %b want 01", c, {err, mem_req});
         end
      end
      tick();
      checks++;
      if ({err, mem_req, busy} !== 3'b101) begin
         errors++; $display("FAIL to_err got %b want 101", {err, mem_req, busy});
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL to_halt_ignored got %b want 1", err);
      end
      start_addr = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({err, busy, pc} !== {2'b00, 8'h33}) begin
         errors++; $display("FAIL to_clear got %b%b/%h want 00/33", err, busy, pc);
      end
   endtask
`else
   task automatic test_timeout();
      start_addr = 8'h33; mem_ack = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40; c++) tick();
      checks++;
      if ({err, mem_req, pc} !== {2'b01, 8'h33}) begin
         errors++; $display("FAIL nto_wait got %b%b/%h want 01/33", err, mem_req, pc);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL nto_halt got %b want 0", busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_linear();
      test_branch();
      test_last_jump();
      test_wait();
      test_halt();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_time_limit got running want finished");
      $fatal(1);
   end

endmodule
